rx_downsample_ber: RTL and testbench

// - Receive-side stage fed directly by the raised-cosine polyphase filter output (OS samples/symbol).
// - Decimates to 1 sample/symbol at a selectable phase and slices the sign to a bit.
// - Searches for the symbol latency against the transmitted bit stream.
// - Once aligned, counts received bits and bit errors (BER measurement).

---
 rtl/rx_downsample_ber.sv | 163 ++++++++++++++++
 tb/tb_rx_downsample_ber.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_downsample_ber.sv
// Receive-side decimator and slicer with symbol-latency search and BER counting.
// Fed by the raised-cosine filter output at OS samples per symbol.
module rx_downsample_ber #(
    parameter int OS      = 4,
    parameter int S_IN    = 10,
    parameter int MAX_LAT = 16,
    parameter int N_WIN   = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic                       i_clear,
    input  logic [$clog2(OS)-1:0]      i_phase,
    input  logic signed [S_IN-1:0]     i_filterx,
    input  logic                       i_tx_bit,
    output logic                       o_rx_bit,
    output logic                       o_rx_valid,
    output logic                       o_locked,
    output logic [$clog2(MAX_LAT)-1:0] o_latency,
    output logic [CNT_W-1:0]           o_bit_count,
    output logic [CNT_W-1:0]           o_err_count
);

    localparam int PH_W   = $clog2(OS);
    localparam int LAT_W  = $clog2(MAX_LAT);
    localparam int WIN_W  = $clog2(N_WIN);
    localparam int FILL_W = $clog2(MAX_LAT);

    localparam logic [PH_W-1:0]   CNT_LAST  = PH_W'(OS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MAX_LAT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(N_WIN - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MAX_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEARCH,
        LOCKED
    } state_t;

    state_t              state;
    logic [PH_W-1:0]     cnt;
    logic [PH_W-1:0]     phase_q;
    logic [MAX_LAT-1:0]  tx_ref;
    logic [FILL_W-1:0]   fill;
    logic [WIN_W-1:0]    win;
    logic                win_err;

    logic en_v;
    logic tx_stb;
    logic rx_stb;
    logic rx_bit;
    logic err;
    logic restart;

    // Sign slice: zero and positive samples both decide 1.
    assign en_v    = i_enable & i_valid;
    assign tx_stb  = en_v & (cnt == CNT_LAST);
    assign rx_stb  = en_v & (cnt == i_phase);
    assign rx_bit  = ~i_filterx[S_IN-1];
    assign err     = rx_bit ^ tx_ref[o_latency];
    assign restart = (state != IDLE) & (i_clear | (i_phase != phase_q));

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            phase_q     <= '0;
            tx_ref      <= '0;
            fill        <= '0;
            win         <= '0;
            win_err     <= 1'b0;
            o_rx_bit    <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_locked    <= 1'b0;
            o_latency   <= '0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            phase_q    <= i_phase;
            o_rx_valid <= rx_stb;
            if (rx_stb)
                o_rx_bit <= rx_bit;

            if (!en_v)
                cnt <= '0;
            else if (cnt == CNT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (tx_stb)
                tx_ref <= {tx_ref[MAX_LAT-2:0], i_tx_bit};

            // A restart keeps tx_ref loaded, so FILL is not revisited.
            if (restart) begin
                state       <= SEARCH;
                o_locked    <= 1'b0;
                o_latency   <= '0;
                win         <= '0;
                win_err     <= 1'b0;
                o_bit_count <= '0;
                o_err_count <= '0;
            end else if (state != IDLE && !en_v) begin
                state    <= IDLE;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        o_locked <= 1'b0;
                        if (en_v) begin
                            state <= FILL;
                            fill  <= '0;
                        end
                    end
                    FILL: begin
                        if (tx_stb) begin
                            if (fill == FILL_LAST) begin
                                state     <= SEARCH;
                                o_latency <= '0;
                                win       <= '0;
                                win_err   <= 1'b0;
                            end else begin
                                fill <= fill + 1'b1;
                            end
                        end
                    end
                    SEARCH: begin
                        if (rx_stb) begin
                            if (win == WIN_LAST) begin
                                win     <= '0;
                                win_err <= 1'b0;
                                if (!win_err && !err) begin
                                    state       <= LOCKED;
                                    o_locked    <= 1'b1;
                                    o_bit_count <= '0;
                                    o_err_count <= '0;
                                end else if (o_latency == LAT_LAST) begin
                                    o_latency <= '0;
                                end else begin
                                    o_latency <= o_latency + 1'b1;
                                end
                            end else begin
                                win     <= win + 1'b1;
                                win_err <= win_err | err;
                            end
                        end
                    end
                    LOCKED: begin
                        if (rx_stb && (o_bit_count != '1)) begin
                            o_bit_count <= o_bit_count + 1'b1;
                            o_err_count <= o_err_count + CNT_W'(err);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_downsample_ber.sv
// Directed bench for rx_downsample_ber: PRBS9 alignment, error counting,
// phase change, enable drop, async reset and uncorrelated search.
module tb_rx_downsample_ber;

    logic              clock = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic              i_valid;
    logic              i_clear;
    logic [1:0]        i_phase;
    logic signed [9:0] i_filterx;
    logic              i_tx_bit;
    logic              o_rx_bit;
    logic              o_rx_valid;
    logic              o_locked;
    logic [3:0]        o_latency;
    logic [31:0]       o_bit_count;
    logic [31:0]       o_err_count;

    rx_downsample_ber dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_clear     (i_clear),
        .i_phase     (i_phase),
        .i_filterx   (i_filterx),
        .i_tx_bit    (i_tx_bit),
        .o_rx_bit    (o_rx_bit),
        .o_rx_valid  (o_rx_valid),
        .o_locked    (o_locked),
        .o_latency   (o_latency),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model of the symbol timing and transmitted history.
    int        pc = 0;
    logic      b = 1'b0;
    logic [8:0]  s9 = 9'h1FF;
    logic [14:0] s15 = 15'h1234;
    logic [15:0] hist = '0;
    logic      inv = 1'b0;
    logic      zero = 1'b0;
    logic      nc = 1'b0;
    int        bad_rx = 0;
    int        n_valid = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [9:0] fx_now();
        logic v;
        if (nc)
            return s15[0] ? 10'sd100 : -10'sd100;
        v = hist[5] ^ inv;
        if (zero && v)
            return 10'sd0;
        return v ? 10'sd100 : -10'sd100;
    endfunction

    task automatic cyc();
        logic pend;
        logic pbit;
        logic en;
        logic nb;
        en = i_enable & i_valid;
        i_tx_bit  = b;
        i_filterx = fx_now();
        pend = en && (pc == int'(i_phase));
        pbit = (i_filterx >= 0);
        @(posedge clock);
        #1;
        if (o_rx_valid !== pend || (pend && o_rx_bit !== pbit))
            bad_rx++;
        if (o_rx_valid)
            n_valid++;
        if (!en) begin
            pc = 0;
        end else if (pc == 3) begin
            pc = 0;
            hist = {hist[14:0], b};
            nb = s9[8] ^ s9[4];
            s9 = {s9[7:0], nb};
            b = nb;
            s15 = {s15[13:0], s15[14] ^ s15[13]};
        end else begin
            pc++;
        end
    endtask

    task automatic sym();
        repeat (4) cyc();
    endtask

    task automatic wait_lock(input string tag);
        for (int k = 0; k < 400 && !o_locked; k++)
            sym();
        check({tag, "_locked"}, o_locked, 1);
        check({tag, "_latency"}, o_latency, 5);
        check({tag, "_bits0"}, o_bit_count, 0);
        check({tag, "_errs0"}, o_err_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int bad_step;
        int wraps;
        int lock_seen;
        logic [15:0] seen;

        i_reset = 1'b0;
        i_enable = 1'b0;
        i_valid = 1'b1;
        i_clear = 1'b0;
        i_phase = 2'd2;
        i_filterx = '0;
        i_tx_bit = 1'b0;
        #12;
        check("reset_outputs",
              {o_rx_bit, o_rx_valid, o_locked, o_latency, o_bit_count, o_err_count}, 0);
        @(negedge clock);
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        cyc();
        cyc();
        check("idle_no_lock", o_locked, 0);

        // Alignment at phase 2: sample is hist[5], matching tx_ref[5].
        i_enable = 1'b1;
        wait_lock("align");

        // 1000 locked symbols with 3 inverted and some zero-valued ones.
        n_valid = 0;
        for (int s = 0; s < 1000; s++) begin
            inv  = (s == 100 || s == 500 || s == 900);
            zero = (s % 50 == 7);
            sym();
        end
        inv = 1'b0;
        zero = 1'b0;
        check("err_bits", o_bit_count, 1000);
        check("err_errs", o_err_count, 3);
        check("err_valid_pulses", n_valid, 1000);
        check("err_latency_held", o_latency, 5);

        // Phase change 2->1 at the first cycle of a symbol.
        i_phase = 2'd1;
        cyc();
        check("ph_unlock",
              {o_locked, o_latency, o_bit_count, o_err_count}, 0);
        repeat (3) cyc();
        wait_lock("ph1");

        // Phase 3: rx and tx strobes coincide; compare is pre-shift.
        i_phase = 2'd3;
        sym();
        wait_lock("ph3");
        for (int s = 0; s < 20; s++)
            sym();
        check("ph3_bits", o_bit_count, 20);

        // Enable drop for 10 cycles.
        i_enable = 1'b0;
        repeat (10) cyc();
        check("drop_locked", o_locked, 0);
        check("drop_bits_held", o_bit_count, 20);
        check("drop_lat_held", o_latency, 5);
        i_enable = 1'b1;
        sym();
        check("refill_unlocked", o_locked, 0);
        wait_lock("relock");

        // Async reset mid-symbol while locked.
        for (int s = 0; s < 7; s++)
            sym();
        check("pre_reset_bits", o_bit_count, 7);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_reset",
              {o_rx_bit, o_rx_valid, o_locked, o_latency, o_bit_count, o_err_count}, 0);
        i_enable = 1'b0;
        pc = 0;
        hist = '0;
        @(negedge clock);
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        repeat (3) cyc();
        check("post_reset_idle",
              {o_rx_valid, o_locked, o_latency, o_bit_count}, 0);

        // Uncorrelated samples: search must walk all latencies and wrap.
        nc = 1'b1;
        i_enable = 1'b1;
        repeat (5) sym();
        check("nc_fill", {o_locked, o_latency}, 0);
        prev = 0;
        bad_step = 0;
        wraps = 0;
        lock_seen = 0;
        seen = 16'h0001;
        for (int s = 0; s < 16 + 17 * 32 + 4; s++) begin
            sym();
            if (o_locked)
                lock_seen++;
            if (int'(o_latency) != prev) begin
                if (int'(o_latency) != (prev + 1) % 16)
                    bad_step++;
                if (prev == 15 && o_latency == 0)
                    wraps++;
                prev = int'(o_latency);
            end
            seen[o_latency] = 1'b1;
        end
        check("nc_never_lock", lock_seen, 0);
        check("nc_step", bad_step, 0);
        check("nc_all_lat", seen, 16'hFFFF);
        check("nc_wrap", wraps, 1);

        // Clear restarts search at latency 0.
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        check("clear", {o_locked, o_latency, o_bit_count}, 0);

        check("rx_strobe_bit", bad_rx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
